// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record used by
// the register file, the writeback stages and the write-port arbiter.
package regfile_pkg;

  localparam int DWIDTH   = 64;
  localparam int AWIDTH   = 5;
  localparam int ZERO_REG = 31;

  // One writeback request: destination register index plus write data.
  typedef struct packed {
    logic [AWIDTH-1:0] idx;
    logic [DWIDTH-1:0] data;
  } wr_req_t;

  // Round-robin successor of requester g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starting at the
// pointer; the pointer moves past the winner only when a grant is issued.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Pick the first valid requester in the order ptr, ptr+1, ... (wrapping).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    grant    = '0;
    found    = 1'b0;
    ptr_next = ptr;
    idx      = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_next   = PW'(rr_next(idx, NREQ));
      end
    end
  end

  // Pointer register; holds when nothing is granted (idle or stalled).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NREQ writeback requesters.
// The winning request is registered for one cycle and drives RegWrite /
// WriteRegister / WriteData; the same register is exposed for bypassing.
// Writes to the hard-wired zero register complete their handshake but never
// raise RegWrite.
module regfile_write_arbiter #(
  parameter int NREQ     = 2,
  parameter int DWIDTH   = regfile_pkg::DWIDTH,
  parameter int AWIDTH   = regfile_pkg::AWIDTH,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_stall,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AWIDTH-1:0] req_reg,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   RegWrite,
  output logic [AWIDTH-1:0]      WriteRegister,
  output logic [DWIDTH-1:0]      WriteData,
  output logic                   fwd_valid,
  output logic [AWIDTH-1:0]      fwd_reg,
  output logic [DWIDTH-1:0]      fwd_data
);

  typedef struct packed {
    logic [AWIDTH-1:0] idx;
    logic [DWIDTH-1:0] data;
  } wr_slot_t;

  logic [NREQ-1:0] grant;
  logic            transfer;
  wr_slot_t        sel;
  wr_slot_t        out_q;
  logic            reg_write_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (!wr_stall),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  // One-hot OR-mux of the granted requester's index and data.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.idx  = sel.idx  | req_reg[i*AWIDTH +: AWIDTH];
        sel.data = sel.data | req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Output register: captures each transfer; zero-register writes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      out_q       <= '0;
    end else begin
      reg_write_q <= transfer && (sel.idx != AWIDTH'(ZERO_REG));
      if (transfer) begin
        out_q <= sel;
      end
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = out_q.idx;
  assign WriteData     = out_q.data;
  assign fwd_valid     = reg_write_q;
  assign fwd_reg       = out_q.idx;
  assign fwd_data      = out_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=2): a table of per-cycle
// vectors with hand-computed grants and outputs, plus hand-written reset
// sequences. A behavioural register file records the issued writes.
module tb_regfile_write_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 64;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_stall;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              RegWrite;
  logic [AW-1:0]     WriteRegister;
  logic [DW-1:0]     WriteData;
  logic              fwd_valid;
  logic [AW-1:0]     fwd_reg;
  logic [DW-1:0]     fwd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NREQ     (NREQ),
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .ZERO_REG (31)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_stall      (wr_stall),
    .req_valid     (req_valid),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data)
  );

  // Raw register file: stores whatever the arbiter issues, so a write to X31
  // that slips through shows up as a nonzero X31.
  logic [DW-1:0] rf [32];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite) begin
      rf[WriteRegister] <= WriteData;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  r0;
    logic [63:0] d0;
    logic [4:0]  r1;
    logic [63:0] d1;
    logic        stall;
    logic [1:0]  ready;   // expected combinational grant
    logic        wr;      // expected RegWrite after the edge
    logic [4:0]  wreg;    // expected WriteRegister after the edge
    logic [63:0] wdata;   // expected WriteData after the edge
    logic        chk_addr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [1:0] valid, input logic [4:0] r0, input logic [63:0] d0,
                              input logic [4:0] r1, input logic [63:0] d1, input logic stall,
                              input logic [1:0] ready, input logic wr, input logic [4:0] wreg,
                              input logic [63:0] wdata, input logic chk_addr);
    vec_t v;
    v.valid = valid; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.stall = stall;
    v.ready = ready; v.wr = wr; v.wreg = wreg; v.wdata = wdata; v.chk_addr = chk_addr;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] valid, input logic [4:0] r0, input logic [63:0] d0,
                       input logic [4:0] r1, input logic [63:0] d1, input logic stall);
    req_valid = valid;
    req_reg   = {r1, r0};
    req_data  = {d1, d0};
    wr_stall  = stall;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_wr;

    // valid  r0  d0                      r1  d1       stall ready wr wreg wdata                  chk
    add(2'b01, 5, 64'hDEAD_BEEF_0000_0001, 0, 0,       0, 2'b01, 1, 5,  64'hDEAD_BEEF_0000_0001, 1);
    add(2'b00, 5, 64'hDEAD_BEEF_0000_0001, 0, 0,       0, 2'b00, 0, 5,  64'hDEAD_BEEF_0000_0001, 1);
    add(2'b10, 0, 0,                       3, 'h33,    0, 2'b10, 1, 3,  'h33,  1);  // ptr -> 0
    add(2'b11, 1, 'h100,                   2, 'h200,   0, 2'b01, 1, 1,  'h100, 1);
    add(2'b11, 1, 'h101,                   2, 'h200,   0, 2'b10, 1, 2,  'h200, 1);
    add(2'b11, 1, 'h101,                   2, 'h201,   0, 2'b01, 1, 1,  'h101, 1);
    add(2'b11, 1, 'h102,                   2, 'h201,   0, 2'b10, 1, 2,  'h201, 1);
    add(2'b01, 8, 'h88,                    0, 0,       0, 2'b01, 1, 8,  'h88,  1);  // ptr -> 1
    add(2'b10, 0, 0,                      31, 'h1234,  0, 2'b10, 0, 0,  0,     0);  // zero reg, ptr -> 0
    add(2'b11, 4, 'h44,                    6, 'h66,    0, 2'b01, 1, 4,  'h44,  1);  // ptr -> 1
    add(2'b11, 9, 'h99,                    6, 'h66,    1, 2'b00, 0, 4,  'h44,  1);  // stall x3
    add(2'b11, 9, 'h99,                    6, 'h66,    1, 2'b00, 0, 4,  'h44,  1);
    add(2'b11, 9, 'h99,                    6, 'h66,    1, 2'b00, 0, 4,  'h44,  1);
    add(2'b11, 9, 'h99,                    6, 'h66,    0, 2'b10, 1, 6,  'h66,  1);  // last grant 0 -> 1 wins
    add(2'b01, 9, 'h99,                    0, 0,       0, 2'b01, 1, 9,  'h99,  1);  // ptr -> 1
    add(2'b10, 0, 0,                      10, 'hAA,    0, 2'b10, 1, 10, 'hAA,  1);  // ptr -> 0
    add(2'b11, 7, 'hA,                     7, 'hB,     0, 2'b01, 1, 7,  'hA,   1);  // same register
    add(2'b10, 0, 0,                       7, 'hB,     0, 2'b10, 1, 7,  'hB,   1);
    add(2'b00, 0, 0,                       0, 0,       0, 2'b00, 0, 7,  'hB,   1);

    // Reset state
    reset = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_regwrite", {63'd0, RegWrite}, 64'd0);
    check("reset_wreg", {59'd0, WriteRegister}, 64'd0);
    check("reset_wdata", WriteData, 64'd0);
    check("reset_ready", {62'd0, req_ready}, 64'd0);
    reset = 1'b0;

    prev_wr = 1'b0;
    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].valid, vq[k].r0, vq[k].d0, vq[k].r1, vq[k].d1, vq[k].stall);
      #1;
      check($sformatf("v%0d_ready", k), {62'd0, req_ready}, {62'd0, vq[k].ready});
      check($sformatf("v%0d_pre_regwrite", k), {63'd0, RegWrite}, {63'd0, prev_wr});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_regwrite", k), {63'd0, RegWrite}, {63'd0, vq[k].wr});
      check($sformatf("v%0d_fwd_valid", k), {63'd0, fwd_valid}, {63'd0, vq[k].wr});
      if (vq[k].chk_addr) begin
        check($sformatf("v%0d_wreg", k), {59'd0, WriteRegister}, {59'd0, vq[k].wreg});
        check($sformatf("v%0d_wdata", k), WriteData, vq[k].wdata);
        check($sformatf("v%0d_fwd_reg", k), {59'd0, fwd_reg}, {59'd0, vq[k].wreg});
        check($sformatf("v%0d_fwd_data", k), fwd_data, vq[k].wdata);
      end
      prev_wr = vq[k].wr;
    end

    // Register-file contents after the table
    @(negedge clk);
    check("rf_x7_last_grant", rf[7], 64'hB);
    check("rf_x31_zero", rf[31], 64'd0);
    check("rf_x5", rf[5], 64'hDEAD_BEEF_0000_0001);
    check("rf_x2", rf[2], 64'h201);

    // Reset while a write is in flight: outputs clear before any edge,
    // and the pointer (advanced to 1 by this grant) returns to 0.
    drive(2'b01, 12, 'hCC, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    check("inflight_regwrite", {63'd0, RegWrite}, 64'd1);
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_reset_regwrite", {63'd0, RegWrite}, 64'd0);
    check("async_reset_wreg", {59'd0, WriteRegister}, 64'd0);
    check("async_reset_wdata", WriteData, 64'd0);
    check("async_reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 13, 'hD13, 14, 'hD14, 1'b0);
    #1;
    check("post_reset_ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("post_reset_wreg", {59'd0, WriteRegister}, 64'd13);
    check("post_reset_wdata", WriteData, 64'hD13);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between NREQ writeback requesters (e.g. ALU result, memory load data).
- Arbitrates round-robin with a per-requester valid/ready handshake.
- Registers the winning write and drives the register file's RegWrite, WriteRegister and WriteData inputs directly.
- Exposes the in-flight write for forwarding, and suppresses writes to the hard-wired zero register.

Parameters:
- NREQ, 2, number of writeback requesters (2..8)
- DWIDTH, 64, data width of the register file
- AWIDTH, 5, register index width (32 registers)
- ZERO_REG, 31, index of the hard-wired zero register; writes to it are never issued

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- wr_stall  input  1  datapath stall; while high no requester is granted
- req_valid  input  NREQ  request i has a write pending
- req_reg  input  NREQ*AWIDTH  destination index for requester i, packed, i at [i*AWIDTH +: AWIDTH]
- req_data  input  NREQ*DWIDTH  write data for requester i, packed likewise
- req_ready  output  NREQ  one-hot grant; the request is consumed in this cycle
- RegWrite  output  1  write enable to the register file
- WriteRegister  output  AWIDTH  destination index to the register file
- WriteData  output  DWIDTH  data to the register file
- fwd_valid  output  1  equals RegWrite; an in-flight write is visible for bypass
- fwd_reg  output  AWIDTH  equals WriteRegister
- fwd_data  output  DWIDTH  equals WriteData

Behaviour:
- Reset (asynchronous, active-high):
  - RegWrite=0, WriteRegister=0, WriteData=0, round-robin pointer=0.
  - A registered write in flight when reset asserts is discarded.
- Handshake:
  - req_ready[i] is combinational: at most one bit high per cycle, only when req_valid[i]=1 and wr_stall=0.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
  - A requester holds req_valid, req_reg and req_data stable until it is granted; req_ready never depends on a requester's own ready.
- Arbitration:
  - Search starts at pointer p and takes the first valid requester in the order p, p+1, ..., wrapping modulo NREQ.
  - After a grant to requester g, p becomes (g+1) mod NREQ.
  - With no grant, including during stall, p is unchanged.
- Output stage, one cycle of latency:
  - A transfer at edge N sets WriteRegister/WriteData to the granted requester's reg/data.
  - RegWrite=1 during cycle N+1; the register file commits at the end of N+1.
  - With no transfer at an edge, RegWrite=0 next cycle and WriteRegister/WriteData hold their previous values.
- Zero register:
  - A granted request with req_reg==ZERO_REG completes its handshake (ready high, pointer advances).
  - The next-cycle RegWrite is 0.
- Back-to-back:
  - A new grant is allowed every cycle; the output stage never stalls the handshake.
- Simultaneous requests to the same register:
  - These are served in arbitration order, one per cycle.
  - The later grant's data is the final register contents.
- Stall:
  - wr_stall=1 forces req_ready=0.
  - A write already registered still issues (RegWrite=1) in the following cycle; stall does not cancel it.
- Forwarding:
  - fwd_* mirror the output register, so a reader in cycle N+1 bypasses the value the register file does not yet return.

Decomposition:
- Package regfile_pkg: DWIDTH, AWIDTH, ZERO_REG constants and a typedef wr_req_t {reg idx, data}, shared with the register file and the writeback stages.
- One sub-module, rr_arbiter (parameter NREQ):
  - Inputs: req vector, enable (the inverse of wr_stall).
  - Outputs: one-hot grant.
  - Owns the pointer register and receives the same clk/reset.
- The top module holds the data mux, zero-register check and output register.

Test Plan:
- Reset during cycle with RegWrite=1 -> RegWrite=0, WriteRegister=0, WriteData=0 immediately (before clock edge); pointer=0, so requester 0 wins the first later contention.
- Single requester 0: reg=5, data=64'hDEAD_BEEF_0000_0001 -> req_ready[0]=1 same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=that value, fwd_valid=1; following cycle RegWrite=0.
- Both valid for 4 cycles, each holding its own new request (reg 1/2) -> grants alternate 0,1,0,1; RegWrite=1 on four consecutive cycles with WriteRegister 1,2,1,2.
- Requester 1 writes reg=31, data=64'h1234 -> req_ready[1]=1, pointer advances, next-cycle RegWrite=0; a later read of X31 stays 0.
- wr_stall=1 for 3 cycles with both valid, entered the cycle after a grant -> req_ready=0 throughout; the already-registered write still shows RegWrite=1 in the first stall cycle; after stall, requester (last_grant+1) wins.
- Both requesters target reg 7 (data 64'hA then 64'hB) -> two consecutive issues in arbitration order; the register file holds the second-granted value; fwd_data matches each in turn.
